// File: rtl/vga_pkg.sv
// Shared VGA timing constants plus the rectangle controller command/state types.
package vga_pkg;

   localparam int HOR_PIXELS = 800;
   localparam int VER_PIXELS = 600;
   localparam int COORD_W    = 11;

   typedef enum logic [1:0] {
      NOP     = 2'd0,
      SET_POS = 2'd1,
      START   = 2'd2,
      STOP    = 2'd3
   } rect_cmd_e;

   typedef enum logic {
      IDLE = 1'b0,
      MOVE = 1'b1
   } rect_state_e;

endpackage

// File: rtl/frame_tick.sv
// One-cycle frame tick on the rising edge of vblnk; shared by frame-synchronous blocks.
module frame_tick (
   input  logic clk,
   input  logic rst,
   input  logic vblnk,
   output logic tick
);

   logic r_vblnk_d;

   always_ff @(posedge clk) begin
      if (rst) r_vblnk_d <= 1'b0;
      else     r_vblnk_d <= vblnk;
   end

   assign tick = vblnk & ~r_vblnk_d;

endmodule

// File: rtl/rect_ctl.sv
// Frame-synchronous rectangle position controller: buffers one command, applies it at vblank start.
// Build option RECT_CTL_WRAP_EN: axes wrap around the screen instead of bouncing off the edges.
module rect_ctl
   import vga_pkg::*;
#(
   parameter int RECT_W    = 350,
   parameter int RECT_H    = 200,
   parameter int STEP      = 2,
   parameter int FRAME_DIV = 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               vblnk,
   input  logic               cmd_valid,
   output logic               cmd_ready,
   input  logic [1:0]         cmd_op,
   input  logic [COORD_W-1:0] cmd_x,
   input  logic [COORD_W-1:0] cmd_y,
   output logic [COORD_W-1:0] xpos,
   output logic [COORD_W-1:0] ypos,
   output logic               moving
);

   localparam int X_MAX = HOR_PIXELS - RECT_W;
   localparam int Y_MAX = VER_PIXELS - RECT_H;
   localparam int CNT_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;

   localparam logic [COORD_W-1:0] X_MAX_C  = COORD_W'(X_MAX);
   localparam logic [COORD_W-1:0] Y_MAX_C  = COORD_W'(Y_MAX);
   localparam logic [11:0]        X_MAX_12 = 12'(X_MAX);
   localparam logic [11:0]        Y_MAX_12 = 12'(Y_MAX);
   localparam logic [11:0]        STEP_12  = 12'(STEP);
   localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(FRAME_DIV - 1);

   // Returns {new_dir, new_pos} for one animation step on one axis.
   function automatic logic [12:0] step_axis(input logic [11:0] pos,
                                             input logic [11:0] lim,
                                             input logic        dir);
      logic [11:0] sum;
      sum = pos + STEP_12;
`ifdef RECT_CTL_WRAP_EN
      if (dir) step_axis = (sum > lim)     ? {dir, sum - lim - 12'd1}            : {dir, sum};
      else     step_axis = (pos < STEP_12) ? {dir, lim + 12'd1 - (STEP_12 - pos)} : {dir, pos - STEP_12};
`else
      if (dir) step_axis = (sum >= lim)     ? {1'b0, lim}   : {1'b1, sum};
      else     step_axis = (pos <= STEP_12) ? {1'b1, 12'd0} : {1'b0, pos - STEP_12};
`endif
   endfunction

   logic               w_tick;
   rect_state_e        r_state, w_state_next;
   logic [COORD_W-1:0] r_x, w_x_next, r_y, w_y_next;
   logic               r_dx, w_dx_next, r_dy, w_dy_next;
   logic [CNT_W-1:0]   r_cnt, w_cnt_next;
   logic               r_pend_valid;
   rect_cmd_e          r_pend_op;
   logic [COORD_W-1:0] r_pend_x, r_pend_y;
   logic [12:0]        w_xs, w_ys;
   logic               w_applied_set;

   frame_tick u_frame_tick (
      .clk   (clk),
      .rst   (rst),
      .vblnk (vblnk),
      .tick  (w_tick)
   );

   assign w_xs = step_axis({1'b0, r_x}, X_MAX_12, r_dx);
   assign w_ys = step_axis({1'b0, r_y}, Y_MAX_12, r_dy);
   assign w_applied_set = r_pend_valid && (r_pend_op == SET_POS);

   always_comb begin
      w_state_next = r_state;
      w_x_next     = r_x;
      w_y_next     = r_y;
      w_dx_next    = r_dx;
      w_dy_next    = r_dy;
      w_cnt_next   = r_cnt;
      if (w_tick) begin
         if (r_pend_valid) begin
            case (r_pend_op)
               SET_POS: begin
                  w_x_next = (r_pend_x > X_MAX_C) ? X_MAX_C : r_pend_x;
                  w_y_next = (r_pend_y > Y_MAX_C) ? Y_MAX_C : r_pend_y;
               end
               START:   w_state_next = MOVE;
               STOP:    w_state_next = IDLE;
               default: ;
            endcase
         end
         // Stepping follows the post-command state, so START steps at once and STOP freezes at once.
         if (w_state_next == MOVE && !w_applied_set) begin
            if (r_cnt == CNT_LAST) begin
               w_cnt_next = '0;
               w_x_next   = w_xs[COORD_W-1:0];
               w_dx_next  = w_xs[12];
               w_y_next   = w_ys[COORD_W-1:0];
               w_dy_next  = w_ys[12];
            end else begin
               w_cnt_next = r_cnt + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_x     <= COORD_W'(X_MAX / 2);
         r_y     <= COORD_W'(Y_MAX / 2);
         r_dx    <= 1'b1;
         r_dy    <= 1'b1;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_next;
         r_x     <= w_x_next;
         r_y     <= w_y_next;
         r_dx    <= w_dx_next;
         r_dy    <= w_dy_next;
         r_cnt   <= w_cnt_next;
      end
   end

   // A command accepted in the tick cycle lands after the clear, so it waits for the next tick.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_pend_valid <= 1'b0;
         r_pend_op    <= NOP;
         r_pend_x     <= '0;
         r_pend_y     <= '0;
      end else begin
         if (w_tick) r_pend_valid <= 1'b0;
         if (cmd_valid && cmd_ready) begin
            r_pend_valid <= 1'b1;
            r_pend_op    <= rect_cmd_e'(cmd_op);
            r_pend_x     <= cmd_x;
            r_pend_y     <= cmd_y;
         end
      end
   end

   assign cmd_ready = ~r_pend_valid;
   assign xpos      = r_x;
   assign ypos      = r_y;
   assign moving    = (r_state == MOVE);

endmodule
